// File: rtl/mem_rd_pkg.sv
// Shared constants, FSM state type and helpers for the memory scan reader.
package mem_rd_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Requested lengths beyond the memory depth read every word exactly once.
  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
    logic [ADDR_W:0] depth_v;
    depth_v = (ADDR_W+1)'(DEPTH);
    return (l > depth_v) ? depth_v : l;
  endfunction

  // Number of words a single fetch takes from the remaining count (0, 1 or 2).
  function automatic logic [ADDR_W:0] fetch_amt(input logic [ADDR_W:0] r);
    logic [ADDR_W:0] two_v;
    two_v = (ADDR_W+1)'(2);
    return (r >= two_v) ? two_v : r;
  endfunction

endpackage

// File: rtl/mem_rd_buf.sv
// Two-entry shift buffer between the dual read ports and the byte stream.
// Head is always slot0; a pop shifts slot1 down.
module mem_rd_buf
  import mem_rd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_two,
  input  logic              pop,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [1:0]        cnt,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;

  // Buffer contents: load wins over pop because a load is only issued when
  // the buffer is empty once this cycle's pop (if any) is taken into account.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (load) begin
      slot0 <= d0;
      if (load_two) begin
        slot1 <= d1;
      end
      cnt <= load_two ? 2'd2 : 2'd1;
    end else if (pop && (cnt != 2'd0)) begin
      slot0 <= slot1;
      cnt   <= cnt - 2'd1;
    end
  end

  assign head = slot0;

endmodule

// File: rtl/mem_scan_reader.sv
// Scans [base, base+len) mod 16 of the main memory through both async read
// ports, two bytes per fetch, and streams the bytes out on valid/ready while
// accumulating their sum.
module mem_scan_reader
  import mem_rd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W:0]   len_sat;
  logic [SUM_W-1:0]  sum_q;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] head;
  logic              start_ok;
  logic              hs;
  logic              fetch;
  logic              take_two;
  logic              final_hs;

  assign len_sat  = sat_len(len);
  assign start_ok = (state == IDLE) && start;
  assign m_valid  = (cnt != 2'd0);
  assign hs       = m_valid && m_ready;
  assign m_last   = (rem == '0) && (cnt == 2'd1);
  assign final_hs = hs && m_last;
  assign take_two = (rem >= (ADDR_W+1)'(2));

  // Refill only when the buffer will be empty after this cycle's pop, so a
  // single-entry buffer being drained is topped up without a bubble.
  assign fetch = (state == SCAN) && (rem != '0) &&
                 ((cnt == 2'd0) || ((cnt == 2'd1) && hs));

  assign rd_addr0 = ptr;
  assign rd_addr1 = ptr + ADDR_W'(1);
  assign m_data   = head;
  assign sum      = sum_q;

  mem_rd_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (fetch),
    .load_two (take_two),
    .pop      (hs),
    .d0       (rd_data0),
    .d1       (rd_data1),
    .cnt      (cnt),
    .head     (head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: an empty scan goes straight to DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len_sat == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (final_hs) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SCAN:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Address pointer, remaining count and byte accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      rem   <= '0;
      sum_q <= '0;
    end else if (start_ok) begin
      ptr   <= base;
      rem   <= len_sat;
      sum_q <= '0;
    end else begin
      if (fetch) begin
        ptr <= ptr + ADDR_W'(2);
        rem <= rem - fetch_amt(rem);
      end
      if (hs) begin
        sum_q <= sum_q + SUM_W'(head);
      end
    end
  end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Scoreboard bench for mem_scan_reader: a 16x8 memory model feeds the read
// ports, each scan pushes its expected byte stream and sum, and a monitor
// compares everything the DUT presents.
`timescale 1ns/1ps
module tb_mem_scan_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] base;
  logic [4:0] len;
  logic [3:0] rd_addr0, rd_addr1;
  logic [7:0] rd_data0, rd_data1;
  logic       m_valid, m_ready, m_last, busy, done;
  logic [7:0] m_data;
  logic [11:0] sum;

  logic [7:0] ram [16];
  assign rd_data0 = ram[rd_addr0];
  assign rd_data1 = ram[rd_addr1];

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   sum_q[$];
  int   compares = 0;
  int   fails    = 0;

  mem_scan_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .len      (len),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    compares++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, got, got, want, want, $time);
    end
  endtask

  task automatic monitor();
    bit         prev_stall = 0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m_valid && prev_stall) begin
          chk("stall_data", int'(m_data), int'(prev_data));
          chk("stall_last", int'(m_last), int'(prev_last));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(m_data), -1);
          end else begin
            e = exp_q.pop_front();
            chk("data", int'(m_data), int'(e.d));
            chk("last", int'(m_last), int'(e.l));
          end
        end
        if (done) begin
          if (sum_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("sum_at_done", int'(sum), sum_q.pop_front());
          end
          chk("busy_in_done", int'(busy), 0);
          chk("bytes_left_at_done", exp_q.size(), 0);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return (k >= 2) && (((k - 2) % 3) == 0);
      default: return 1'b1;
    endcase
  endfunction

  // Reference: n = min(len,16) bytes ram[(b+i) mod 16], last on the final one.
  task automatic push_model(input int b, input int l, output int n, output int s);
    exp_t e;
    n = (l > 16) ? 16 : l;
    s = 0;
    for (int i = 0; i < n; i++) begin
      e.d = ram[(b + i) % 16];
      e.l = (i == n - 1);
      exp_q.push_back(e);
      s += int'(ram[(b + i) % 16]);
    end
    sum_q.push_back(s);
  endtask

  task automatic run_scan(input int b, input int l, input int mode, input bit mid);
    int n, s, k;
    bit seen;
    push_model(b, l, n, s);
    @(posedge clk); #1;
    start = 1'b1; base = 4'(b); len = 5'(l);
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    m_ready = ready_for(mode, k);
    seen = 0;
    while (k < 400 && !seen) begin
      @(negedge clk);
      if (k == 1 && n > 0) begin
        chk("first_fetch_addr0", int'(rd_addr0), b);
        chk("first_fetch_addr1", int'(rd_addr1), (b + 1) % 16);
        chk("no_valid_at_t1", int'(m_valid), 0);
        chk("busy_at_t1", int'(busy), 1);
      end
      if (k == 2 && n > 0 && mode == 0) chk("valid_at_t2", int'(m_valid), 1);
      if (done) begin
        seen = 1;
        if (mode == 0) chk("done_latency", k, (n == 0) ? 1 : n + 2);
      end else begin
        @(posedge clk); #1;
        k++;
        start = mid && (k == 3);
        if (mid && k == 3) begin
          base = 4'd9; len = 5'd7;
        end
        m_ready = ready_for(mode, k);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);
    chk("sum_held", int'(sum), s);
  endtask

  task automatic reset_mid_scan();
    int n, s, got;
    push_model(0, 16, n, s);
    @(posedge clk); #1;
    start = 1'b1; base = 4'd0; len = 5'd16; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 100 && got < 3; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) got++;
      @(posedge clk); #1;
    end
    chk("bytes_before_reset", got, 3);
    reset = 1'b1; m_ready = 1'b0;
    exp_q.delete();
    sum_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_addr0", int'(rd_addr0), 0);
    for (int k = 0; k < 5; k++) begin
      chk("no_done_after_reset", int'(done), 0);
      @(negedge clk);
    end
  endtask

  task automatic stimulus();
    reset = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", int'(m_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sum", int'(sum), 0);
    chk("reset_last", int'(m_last), 0);
    chk("reset_addr0", int'(rd_addr0), 0);
    chk("reset_addr1", int'(rd_addr1), 1);

    run_scan(0, 16, 0, 0);
    run_scan(14, 4, 0, 0);
    run_scan(5, 1, 0, 0);
    run_scan(9, 0, 0, 0);
    run_scan(3, 5, 2, 0);
    run_scan(7, 20, 0, 0);
    ram[6] = 8'hAA;
    run_scan(6, 2, 0, 1);
    reset_mid_scan();
    run_scan(2, 5, 1, 0);

    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 2) == 0) ram[$urandom_range(0, 15)] = 8'($urandom);
      run_scan(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size() + sum_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #2000000;
        chk("global_timeout", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $fatal(1, "simulation time limit reached");
      end
    join_any
  end

endmodule
